// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and forwarding controller beside the ID stage.
// Tracks destination tags of in-flight stages past ID.
module pipeline_hazard_ctrl #(
  parameter int NUM_SRC    = 3,
  parameter int REG_AW     = 4,
  parameter int FWD_STAGES = 3,
  parameter int LOAD_STAGE = 2,
  parameter int PC_REG     = 15,
  parameter int SEL_W      = $clog2(FWD_STAGES + 1)
) (
  input  logic                      CLK,
  input  logic                      CLR,
  input  logic                      id_valid,
  input  logic                      id_rf_we,
  input  logic                      id_is_load,
  input  logic [REG_AW-1:0]         id_rd,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic                      br_taken,
  input  logic                      mem_busy,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
  output logic                      pc_le,
  output logic                      ifid_le,
  output logic                      nop_sel,
  output logic                      ifid_flush,
  output logic [15:0]               stall_cnt,
  output logic [15:0]               busy_cnt
);

  localparam logic [REG_AW-1:0] PC_TAG = REG_AW'(PC_REG);

  logic [FWD_STAGES-1:0] tv;
  logic [FWD_STAGES-1:0] tl;
  logic [REG_AW-1:0]     trd [FWD_STAGES];

  logic [SEL_W-1:0]   sel_y [NUM_SRC];
  logic [NUM_SRC-1:0] ld_y;
  logic [NUM_SRC-1:0] hz;
  logic               load_stall;
  logic               id_v;

  assign id_v = id_valid & id_rf_we & (id_rd != PC_TAG);

  // youngest matching writer per source, and load-use detection
  always_comb begin
    fwd_sel = '0;
    hz      = '0;
    ld_y    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      sel_y[i] = '0;
      for (int k = FWD_STAGES; k >= 1; k--) begin
        if (id_src_used[i] && tv[k-1] &&
            trd[k-1] == id_src[i*REG_AW +: REG_AW] &&
            id_src[i*REG_AW +: REG_AW] != PC_TAG) begin
          sel_y[i] = SEL_W'(k);
          ld_y[i]  = tl[k-1];
        end
      end
      if (ld_y[i] && int'(sel_y[i]) < LOAD_STAGE)
        hz[i] = 1'b1;
      else
        fwd_sel[i*SEL_W +: SEL_W] = sel_y[i];
    end
    load_stall = |hz;
  end

  // pipeline control with freeze > stall > flush precedence
  always_comb begin
    pc_le      = 1'b1;
    ifid_le    = 1'b1;
    nop_sel    = 1'b0;
    ifid_flush = br_taken;
    if (mem_busy) begin
      pc_le      = 1'b0;
      ifid_le    = 1'b0;
      ifid_flush = 1'b0;
    end else if (load_stall) begin
      pc_le      = 1'b0;
      ifid_le    = 1'b0;
      nop_sel    = 1'b1;
      ifid_flush = 1'b0;
    end
  end

  // shadow tag pipeline: hold on freeze, bubble on stall
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      tv <= '0;
      tl <= '0;
      for (int j = 0; j < FWD_STAGES; j++)
        trd[j] <= '0;
    end else if (!mem_busy) begin
      for (int j = FWD_STAGES - 1; j >= 1; j--) begin
        tv[j]  <= tv[j-1];
        tl[j]  <= tl[j-1];
        trd[j] <= trd[j-1];
      end
      tv[0]  <= load_stall ? 1'b0 : id_v;
      tl[0]  <= load_stall ? 1'b0 : id_is_load;
      trd[0] <= id_rd;
    end
  end

  // saturating stall and freeze counters
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      stall_cnt <= '0;
      busy_cnt  <= '0;
    end else begin
      if (load_stall && !mem_busy && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
      if (mem_busy && busy_cnt != 16'hFFFF)
        busy_cnt <= busy_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl.
// Hand-computed expectations, immediate assertions.
module tb_pipeline_hazard_ctrl;

  logic        CLK = 1'b0;
  logic        CLR;
  logic        id_valid, id_rf_we, id_is_load;
  logic [3:0]  id_rd;
  logic [11:0] id_src;
  logic [2:0]  id_src_used;
  logic        br_taken, mem_busy;
  logic [5:0]  fwd_sel;
  logic        pc_le, ifid_le, nop_sel, ifid_flush;
  logic [15:0] stall_cnt, busy_cnt;

  int checks = 0;
  int errors = 0;

  pipeline_hazard_ctrl dut (
    .CLK(CLK), .CLR(CLR),
    .id_valid(id_valid), .id_rf_we(id_rf_we),
    .id_is_load(id_is_load), .id_rd(id_rd),
    .id_src(id_src), .id_src_used(id_src_used),
    .br_taken(br_taken), .mem_busy(mem_busy),
    .fwd_sel(fwd_sel), .pc_le(pc_le),
    .ifid_le(ifid_le), .nop_sel(nop_sel),
    .ifid_flush(ifid_flush),
    .stall_cnt(stall_cnt), .busy_cnt(busy_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ctl(input string tag, input logic p,
                     input logic l, input logic n,
                     input logic f);
    chk({tag, ".pc_le"}, 32'(pc_le), 32'(p));
    chk({tag, ".ifid_le"}, 32'(ifid_le), 32'(l));
    chk({tag, ".nop_sel"}, 32'(nop_sel), 32'(n));
    chk({tag, ".flush"}, 32'(ifid_flush), 32'(f));
  endtask

  task automatic fsel(input string tag, input int f0,
                      input int f1, input int f2);
    chk({tag, ".fwd0"}, 32'(fwd_sel[1:0]), 32'(f0));
    chk({tag, ".fwd1"}, 32'(fwd_sel[3:2]), 32'(f1));
    chk({tag, ".fwd2"}, 32'(fwd_sel[5:4]), 32'(f2));
  endtask

  task automatic drive(input logic v, input logic we,
                       input logic ld, input int rd,
                       input int s0, input int s1,
                       input int s2, input logic [2:0] used);
    id_valid    = v;
    id_rf_we    = we;
    id_is_load  = ld;
    id_rd       = 4'(rd);
    id_src      = {4'(s2), 4'(s1), 4'(s0)};
    id_src_used = used;
    #1;
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    CLR = 1'b1;
    br_taken = 1'b0;
    mem_busy = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 3'b000);
    #12;
    ctl("reset", 1, 1, 0, 0);
    fsel("reset", 0, 0, 0);
    chk("reset.stall_cnt", 32'(stall_cnt), 0);
    chk("reset.busy_cnt", 32'(busy_cnt), 0);
    CLR = 1'b0;
    tick();

    // ADD R1 ; SUB R2,R1,R3 ; ORR R4,R1 ; R7 <- R1 ; read R1
    drive(1, 1, 0, 1, 2, 3, 0, 3'b011);
    fsel("add", 0, 0, 0);
    tick();
    drive(1, 1, 0, 2, 1, 3, 0, 3'b011);
    fsel("sub", 1, 0, 0);
    ctl("sub", 1, 1, 0, 0);
    tick();
    drive(1, 1, 0, 4, 1, 0, 0, 3'b011);
    fsel("orr", 2, 0, 0);
    tick();
    drive(1, 1, 0, 7, 1, 0, 0, 3'b001);
    fsel("wb_fwd", 3, 0, 0);
    tick();
    drive(0, 0, 0, 0, 1, 0, 0, 3'b001);
    fsel("aged_out", 0, 0, 0);
    tick();

    // LDR R5 ; ADD R6,R5,R5
    drive(1, 1, 1, 5, 0, 0, 0, 3'b000);
    tick();
    drive(1, 1, 0, 6, 5, 5, 0, 3'b011);
    ctl("ldu", 0, 0, 1, 0);
    fsel("ldu", 0, 0, 0);
    tick();
    chk("ldu.stall_cnt", 32'(stall_cnt), 1);
    ctl("ldu_next", 1, 1, 0, 0);
    fsel("ldu_next", 2, 2, 0);
    tick();

    // R2 in EX and WB, R15 never matched, unused source ignored
    drive(1, 1, 0, 2, 0, 0, 0, 3'b000);
    tick();
    drive(1, 1, 0, 9, 0, 0, 0, 3'b000);
    tick();
    drive(1, 1, 0, 2, 0, 0, 0, 3'b000);
    tick();
    drive(1, 1, 1, 15, 2, 15, 9, 3'b111);
    fsel("dbl", 1, 0, 2);
    ctl("dbl", 1, 1, 0, 0);
    drive(1, 1, 0, 3, 2, 2, 9, 3'b100);
    fsel("unused", 0, 0, 2);
    tick();

    // branch without and with a pending load-use stall
    br_taken = 1'b1;
    drive(1, 1, 1, 8, 0, 0, 0, 3'b000);
    ctl("br", 1, 1, 0, 1);
    br_taken = 1'b0;
    #1;
    tick();
    br_taken = 1'b1;
    drive(1, 1, 0, 3, 8, 0, 0, 3'b001);
    ctl("br_stall", 0, 0, 1, 0);
    tick();
    chk("br_stall.stall_cnt", 32'(stall_cnt), 2);
    ctl("br_clear", 1, 1, 0, 1);
    fsel("br_clear", 2, 0, 0);
    br_taken = 1'b0;
    tick();

    // freeze for three cycles over a load-use stall
    drive(1, 1, 1, 10, 0, 0, 0, 3'b000);
    tick();
    mem_busy = 1'b1;
    br_taken = 1'b1;
    drive(1, 1, 0, 11, 10, 0, 0, 3'b001);
    for (int c = 0; c < 3; c++) begin
      ctl("busy", 0, 0, 0, 0);
      tick();
    end
    chk("busy.busy_cnt", 32'(busy_cnt), 3);
    chk("busy.stall_cnt", 32'(stall_cnt), 2);
    mem_busy = 1'b0;
    br_taken = 1'b0;
    #1;
    ctl("unfreeze", 0, 0, 1, 0);
    fsel("unfreeze", 0, 0, 0);
    tick();
    chk("unfreeze.stall_cnt", 32'(stall_cnt), 3);
    ctl("resume", 1, 1, 0, 0);
    fsel("resume", 2, 0, 0);
    tick();

    // reset asserted in the middle of a stall
    drive(1, 1, 1, 11, 0, 0, 0, 3'b000);
    tick();
    drive(1, 1, 0, 12, 11, 0, 0, 3'b001);
    ctl("pre_clr", 0, 0, 1, 0);
    CLR = 1'b1;
    #1;
    ctl("clr", 1, 1, 0, 0);
    fsel("clr", 0, 0, 0);
    chk("clr.stall_cnt", 32'(stall_cnt), 0);
    chk("clr.busy_cnt", 32'(busy_cnt), 0);
    tick();
    CLR = 1'b0;
    #1;
    fsel("post_clr", 0, 0, 0);
    ctl("post_clr", 1, 1, 0, 0);
    tick();
    drive(1, 1, 0, 13, 12, 0, 0, 3'b001);
    fsel("new_tag", 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
